// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage: data-path widths, the
// default reset PC, the fetch FSM state encoding and a word-align helper.
package fetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Clears the byte-offset bits so the address points at a whole instruction.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small synchronous in-order FIFO with a zero-latency head output.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   flush_i         empties the FIFO; push and pop are ignored that cycle
//   push_i/data_i   write an entry (accepted when not full, or full and popping)
//   pop_i           remove the head entry (ignored when empty)
//   head_o          current head entry
//   count_o         number of stored entries
//   empty_o/full_o  occupancy flags
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; stale contents are never visible past count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory under a credit limit, buffers returned words with their PCs and
// hands them to decode over valid/ready. Redirects flush buffered work and
// mark in-flight responses to be dropped.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   imem_req_valid/ready/addr          fetch request channel
//   imem_rsp_valid/data                in-order fetch responses
//   redirect_valid/pc                  branch/jump redirect from execute
//   instr_valid/ready                  decode handshake
//   instr, instr_pc, instr_pc_plus4    FIFO head word, its PC and PC+4
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q;

  logic            run, redirect, credit_ok, req_fire, rsp_drop, rsp_keep;
  logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]   fifo_count;
  logic [63:0]     fifo_head;
  logic            pcq_push, pcq_pop, pcq_empty, pcq_full;
  logic [CW-1:0]   pcq_count;
  logic [31:0]     pcq_head;

  assign run      = (state_q == RUN);
  assign redirect = run && redirect_valid;

  // Credits cover both in-flight requests and buffered words, so every
  // response that is kept always finds a free FIFO slot.
  assign credit_ok = (SW'(outstanding_q) + SW'(fifo_count)) < SW'(FIFO_DEPTH);

  assign imem_req_valid = run && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_q == '0);

  // Counts accepted-but-unanswered requests, including those marked for drop.
  assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

  // Dropped responses have no PC queue entry: the queue was flushed by the
  // redirect that condemned them.
  assign pcq_push  = req_fire;
  assign pcq_pop   = rsp_keep;
  assign fifo_push = rsp_keep;
  assign fifo_pop  = instr_valid && instr_ready;

  fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pc_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect),
    .push_i     (pcq_push),
    .push_data_i(pc_q),
    .pop_i      (pcq_pop),
    .head_o     (pcq_head),
    .count_o    (pcq_count),
    .empty_o    (pcq_empty),
    .full_o     (pcq_full)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect),
    .push_i     (fifo_push),
    .push_data_i({pcq_head, imem_rsp_data}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign instr_valid    = !fifo_empty;
  assign instr          = fifo_head[31:0];
  assign instr_pc       = fifo_head[63:32];
  assign instr_pc_plus4 = instr_pc + XLEN'(INSTR_BYTES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      case (state_q)
        BOOT:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
      outstanding_q <= outstanding_d;
      if (redirect) begin
        pc_q   <= word_align(redirect_pc);
        // Everything still in flight after this edge belongs to the old path.
        drop_q <= outstanding_d;
      end else begin
        if (req_fire) pc_q   <= pc_q + XLEN'(INSTR_BYTES);
        if (rsp_drop) drop_q <= drop_q - CW'(1);
      end
    end
  end

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0));
  a_counters_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    (outstanding_q <= CW'(FIFO_DEPTH)) && (drop_q <= outstanding_q));
  a_pcq_tracks_live: assert property (@(posedge clk) disable iff (!rst_n)
    pcq_count == (outstanding_q - drop_q));
  a_pcq_has_entry: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> !pcq_empty);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full && !fifo_pop) && !(pcq_push && pcq_full && !pcq_pop));

endmodule
